// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial multi-digit BCD adder/subtractor
//
// Purpose
//   Adds or subtracts two packed-BCD operands one decimal digit per clock,
//   least significant digit first. Subtraction adds the 9's complement of B
//   with an initial carry of 1. A negative difference leaves the 10's
//   complement in the accumulator. A second serial pass (FIX) then converts it
//   to a magnitude plus a sign bit.
//
// Configuration macro
//   BCD_SAT_EN : when defined, an addition overflow saturates the result to all
//                nines. When undefined, an addition overflow wraps modulo
//                10^DIGITS. In both builds carry_out is 1 on overflow.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous active-high reset
//   start      in   1         operation request, sampled only in IDLE
//   op_sub     in   1         0 = A+B, 1 = A-B, latched with start
//   a, b       in   4*DIGITS  packed BCD operands, digit 0 in bits [3:0]
//   busy       out  1         operation in progress
//   done       out  1         one-cycle completion pulse
//   result     out  4*DIGITS  packed BCD magnitude
//   sign       out  1         result negative (subtraction only)
//   carry_out  out  1         decimal overflow (addition only)
//   invalid    out  1         an operand digit was greater than 9

module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                sign,
  output logic                carry_out,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_FIX,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_op_sub;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_acc;
  // Pending flags are staged here and published together with done.
  logic          r_sign_p;
  logic          r_cout_p;
  logic          r_inv_p;

  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_result;
  logic          r_sign;
  logic          r_carry_out;
  logic          r_invalid;

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign sign      = r_sign;
  assign carry_out = r_carry_out;
  assign invalid   = r_invalid;

  // Any operand digit above 9 is rejected at accept time.
  logic w_in_bad;
  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9) w_in_bad = 1'b1;
      if (b[4*i +: 4] > 4'd9) w_in_bad = 1'b1;
    end
  end

  // Shared single-digit decimal adder used by both the ADD and the FIX pass.
  // In FIX the digit being complemented comes from the accumulator and the
  // second operand is zero, so the only addend besides 9-r_i is the carry.
  logic [3:0] w_a_dig;
  logic [3:0] w_b_dig;
  logic [3:0] w_r_dig;
  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [4:0] w_s;
  logic [4:0] w_s_adj;
  logic [3:0] w_dig;
  logic       w_cout;
  logic [W-1:0] w_acc_next;
  logic       w_last;

  always_comb begin
    w_a_dig = r_a[4*int'(r_cnt) +: 4];
    w_b_dig = r_b[4*int'(r_cnt) +: 4];
    w_r_dig = r_acc[4*int'(r_cnt) +: 4];

    if (r_state == S_FIX) begin
      w_x = 4'd9 - w_r_dig;
      w_y = 4'd0;
    end else begin
      w_x = w_a_dig;
      w_y = r_op_sub ? (4'd9 - w_b_dig) : w_b_dig;
    end

    w_s     = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, r_carry};
    w_s_adj = w_s + 5'd6;
    if (w_s > 5'd9) begin
      w_dig  = w_s_adj[3:0];
      w_cout = 1'b1;
    end else begin
      w_dig  = w_s[3:0];
      w_cout = 1'b0;
    end

    w_acc_next = r_acc;
    w_acc_next[4*int'(r_cnt) +: 4] = w_dig;

    w_last = (r_cnt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op_sub    <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_sign_p    <= 1'b0;
      r_cout_p    <= 1'b0;
      r_inv_p     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_sign      <= 1'b0;
      r_carry_out <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_op_sub <= op_sub;
            r_cnt    <= '0;
            r_sign_p <= 1'b0;
            r_cout_p <= 1'b0;
            if (w_in_bad) begin
              r_inv_p <= 1'b1;
              r_acc   <= '0;
              r_state <= S_DONE;
            end else begin
              r_inv_p <= 1'b0;
              r_carry <= op_sub;
              r_busy  <= 1'b1;
              r_state <= S_ADD;
            end
          end
        end

        S_ADD: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt <= '0;
            if (!r_op_sub) begin
              r_cout_p <= w_cout;
`ifdef BCD_SAT_EN
              if (w_cout) r_acc <= {DIGITS{4'h9}};
`endif
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else if (w_cout) begin
              // Carry out of a subtraction means A >= B, including A == B.
              r_sign_p <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              // No carry: accumulator holds the 10's complement of B-A.
              r_sign_p <= 1'b1;
              r_carry  <= 1'b1;
              r_state  <= S_FIX;
            end
          end
        end

        S_FIX: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done      <= 1'b1;
          r_result    <= r_acc;
          r_sign      <= r_sign_p;
          r_carry_out <= r_cout_p;
          r_invalid   <= r_inv_p;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
